popcount_serial: RTL

Parametrised, handshaked population-count engine: accepts a DATA_W-bit word and counts its ones over DATA_W/LANES clock cycles, LANES bits per cycle. It is the sequential, width-generic successor of the three-input gate-level ones counter and serves datapaths that need ones-counts of wide words without a full-width adder tree. Output is registered and held under backpressure; an optional accumulator keeps a running total across words.

---
 rtl/popcount_pkg.sv | 41 ++++
 rtl/popcount_lanes.sv | 27 ++
 rtl/popcount_serial.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/popcount_pkg.sv
// -----------------------------------------------------------------------------
// popcount_pkg
//   Shared definitions for the serial population-count engine.
//   - state_t  : FSM encoding (IDLE=0, COUNT=1, DONE=2)
//   - clog2    : ceiling log2, usable in constant expressions
//   - sat_add  : unsigned add saturating at 2^w - 1 (w <= 32)
// -----------------------------------------------------------------------------
package popcount_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(17) = 5.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            res = i + 1;
         end
      end
      return res;
   endfunction

   // Adds two unsigned operands and clamps the result to the largest value
   // representable in w bits. A 33-bit intermediate keeps the carry of two
   // full 32-bit operands, so the clamp is exact for every w in 1..32.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          w);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << w) - 33'd1;
      return (sum > lim) ? lim[31:0] : sum[31:0];
   endfunction

endpackage

// File: rtl/popcount_lanes.sv
// -----------------------------------------------------------------------------
// popcount_lanes
//   Combinational ones counter over a LANES-bit slice.
//   Parameters:
//     LANES : slice width (>= 1)
//   Ports:
//     bits  in  LANES               bits to count
//     count out clog2(LANES+1)      number of ones in bits
// -----------------------------------------------------------------------------
module popcount_lanes
   import popcount_pkg::*;
#(
   parameter  int LANES = 4,
   localparam int LW    = clog2(LANES + 1)
) (
   input  logic [LANES-1:0] bits,
   output logic [LW-1:0]    count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < LANES; i++) begin
         count = count + LW'(bits[i]);
      end
   end

endmodule

// File: rtl/popcount_serial.sv
// -----------------------------------------------------------------------------
// popcount_serial
//   Handshaked, width-generic population counter. A DATA_W-bit word is taken
//   in IDLE, then counted LANES bits per cycle over N = DATA_W/LANES cycles,
//   and the registered result is held in DONE until the consumer takes it.
//
//   Optional feature (macro POPCOUNT_ACC_EN): a saturating ACC_W-bit running
//   total of all completed counts, with a synchronous clear acc_clr that wins
//   over a completion in the same cycle.
//
//   Parameters:
//     DATA_W : input word width (>= 1)
//     LANES  : bits consumed per COUNT cycle; must divide DATA_W
//     ACC_W  : accumulator width (1..32), used only with POPCOUNT_ACC_EN
//     CNT_W  : derived count width, clog2(DATA_W+1)
//   Ports:
//     clk        in  1       rising-edge clock
//     rst_n      in  1       asynchronous active-low reset
//     in_valid   in  1       in_data valid
//     in_ready   out 1       word can be accepted (state == IDLE)
//     in_data    in  DATA_W  word to count
//     out_valid  out 1       out_count valid
//     out_ready  in  1       consumer takes result
//     out_count  out CNT_W   ones in the accepted word
//     busy       out 1       state != IDLE
//     acc_clr    in  1       synchronous accumulator clear   (POPCOUNT_ACC_EN)
//     acc_total  out ACC_W   saturating running total        (POPCOUNT_ACC_EN)
// -----------------------------------------------------------------------------
module popcount_serial
   import popcount_pkg::*;
#(
   parameter  int DATA_W = 16,
   parameter  int LANES  = 4,
   parameter  int ACC_W  = 16,
   localparam int CNT_W  = clog2(DATA_W + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  out_count,
   output logic              busy
`ifdef POPCOUNT_ACC_EN
   ,
   input  logic              acc_clr,
   output logic [ACC_W-1:0]  acc_total
`endif
);

   localparam int N     = DATA_W / LANES;
   localparam int IDX_W = (N > 1) ? clog2(N) : 1;
   localparam int LW    = clog2(LANES + 1);

   // Elaboration-time parameter sanity checks.
   if (DATA_W < 1 || LANES < 1 || LANES > DATA_W || (DATA_W % LANES) != 0) begin : g_bad_lanes
      $error("popcount_serial: LANES must divide DATA_W and be in 1..DATA_W");
   end
   if (ACC_W < 1 || ACC_W > 32) begin : g_bad_acc
      $error("popcount_serial: ACC_W must be in 1..32");
   end

   state_t              state;
   state_t              state_nxt;
   logic [DATA_W-1:0]   shreg;
   logic [CNT_W-1:0]    partial;
   logic [CNT_W-1:0]    sum;
   logic [IDX_W-1:0]    idx;
   logic [LW-1:0]       lane_cnt;
   logic                last;

   popcount_lanes #(
      .LANES (LANES)
   ) u_lanes (
      .bits  (shreg[LANES-1:0]),
      .count (lane_cnt)
   );

   // Partial sum including the slice currently at the bottom of shreg; on the
   // final COUNT edge this is the complete ones count of the word.
   assign sum  = partial + CNT_W'(lane_cnt);
   assign last = (idx == IDX_W'(N - 1));

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. in_valid is ignored outside IDLE, so an output
   // handshake and a new accept never happen in the same cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = COUNT;
         COUNT:   if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Datapath: shift register, partial sum, slice index, registered result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg     <= '0;
         partial   <= '0;
         idx       <= '0;
         out_count <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shreg   <= in_data;
                  partial <= '0;
                  idx     <= '0;
               end
            end
            COUNT: begin
               partial <= sum;
               shreg   <= shreg >> LANES;
               idx     <= idx + 1'b1;
               if (last) begin
                  out_count <= sum;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef POPCOUNT_ACC_EN
   // Running total; a clear in the completion cycle drops that word's count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_total <= '0;
      end else if (acc_clr) begin
         acc_total <= '0;
      end else if (state == COUNT && last) begin
         acc_total <= ACC_W'(sat_add(32'(acc_total), 32'(sum), ACC_W));
      end
   end
`endif

endmodule
